// File: rtl/uart_serial_ctrl_pkg.sv
// Shared constants and types for the MMU-facing serial port responder.
package uart_serial_ctrl_pkg;

  // Strobe polarity as driven by the MMU
  localparam logic ENABLE    = 1'b1;
  localparam logic MEM_WRITE = 1'b1;

  // Bit positions of the two status flags as the MMU sees them
  localparam int STAT_SEND_COMPLETE    = 0;
  localparam int STAT_RECEIVE_COMPLETE = 1;

  // Level of an idle UART line (also the stop-bit level)
  localparam logic UART_IDLE = 1'b1;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // Assemble the status pair in MMU bit order
  function automatic logic [1:0] status_bits(input logic send_done, input logic recv_avail);
    logic [1:0] s;
    s = '0;
    s[STAT_SEND_COMPLETE]    = send_done;
    s[STAT_RECEIVE_COMPLETE] = recv_avail;
    return s;
  endfunction

endpackage

// File: rtl/uart_serial_ctrl_if.sv
// MMU <-> serial responder bus: level strobes in, data and status out.
interface uart_serial_ctrl_if;
  import uart_serial_ctrl_pkg::*;

  logic              serial_enable;
  logic              serial_readWrite;
  logic              serial_fetch_data;
  logic [BYTE_W-1:0] serial_dataWrite;
  logic [BYTE_W-1:0] serial_dataRead;
  logic              send_complete;
  logic              receive_complete;
  logic              rx_overrun;

  modport master (
    output serial_enable,
    output serial_readWrite,
    output serial_fetch_data,
    output serial_dataWrite,
    input  serial_dataRead,
    input  send_complete,
    input  receive_complete,
    input  rx_overrun
  );

  modport slave (
    input  serial_enable,
    input  serial_readWrite,
    input  serial_fetch_data,
    input  serial_dataWrite,
    output serial_dataRead,
    output send_complete,
    output receive_complete,
    output rx_overrun
  );

endinterface

// File: rtl/uart_serial_ctrl_rx_fifo.sv
// Show-ahead receive FIFO. A push while full only lands when a pop frees
// the slot in the same cycle; otherwise the byte is discarded.
module uart_rx_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic        [DATA_W-1:0]     din,
  output logic        [DATA_W-1:0]     dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_serial_ctrl.sv
// Serial-port responder behind the MMU: 8N1 transmitter fed by CPU writes,
// 8N1 receiver feeding a small FIFO drained by CPU reads, plus status flags.
module uart_serial_ctrl
  import uart_serial_ctrl_pkg::*;
#(
  parameter int CLKS_PER_BIT = 96,
  parameter int RX_DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_serial_ctrl_if.slave bus,
  input  logic              uart_rxd,
  output logic              uart_txd
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int FCNT_W = $clog2(RX_DEPTH) + 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [2:0]       LAST_BIT  = 3'd7;

  // ---------------- strobe edge detection ----------------
  logic wr_lvl;
  logic fetch_lvl;
  logic wr_lvl_p0;
  logic fetch_lvl_p0;
  logic wr_edge;
  logic fetch_edge;

  assign wr_lvl     = (bus.serial_enable == ENABLE) && (bus.serial_readWrite == MEM_WRITE);
  assign fetch_lvl  = (bus.serial_enable == ENABLE) && (bus.serial_fetch_data == ENABLE);
  assign wr_edge    = wr_lvl & ~wr_lvl_p0;
  assign fetch_edge = fetch_lvl & ~fetch_lvl_p0;

  // Remember last cycle's strobe levels so a held strobe fires only once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_lvl_p0    <= 1'b0;
      fetch_lvl_p0 <= 1'b0;
    end else begin
      wr_lvl_p0    <= wr_lvl;
      fetch_lvl_p0 <= fetch_lvl;
    end
  end

  // ---------------- transmitter ----------------
  tx_state_t         tx_state;
  tx_state_t         tx_next;
  logic [CNT_W-1:0]  tx_cnt;
  logic [2:0]        tx_bit;
  logic [BYTE_W-1:0] tx_shift;
  logic              tx_line;
  logic              tx_idle;
  logic              tx_bit_end;

  assign tx_bit_end = (tx_cnt == BIT_LAST);

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tx_state <= TX_IDLE;
    else      tx_state <= tx_next;
  end

  // TX next state: each non-idle state lasts whole bit periods
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (wr_edge)                             tx_next = TX_START;
      TX_START: if (tx_bit_end)                          tx_next = TX_DATA;
      TX_DATA:  if (tx_bit_end && (tx_bit == LAST_BIT))  tx_next = TX_STOP;
      TX_STOP:  if (tx_bit_end)                          tx_next = TX_IDLE;
      default:                                           tx_next = TX_IDLE;
    endcase
  end

  // TX outputs: line level and idle flag decode straight from state
  always_comb begin
    tx_line = UART_IDLE;
    tx_idle = 1'b0;
    case (tx_state)
      TX_IDLE:  begin tx_line = UART_IDLE; tx_idle = 1'b1; end
      TX_START: tx_line = ~UART_IDLE;
      TX_DATA:  tx_line = tx_shift[0];
      TX_STOP:  tx_line = UART_IDLE;
      default:  tx_line = UART_IDLE;
    endcase
  end

  // TX baud counter and bit index; held at zero while idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_state == TX_IDLE) begin
      tx_cnt <= '0;
      tx_bit <= '0;
    end else if (tx_bit_end) begin
      tx_cnt <= '0;
      if (tx_state == TX_DATA) tx_bit <= tx_bit + 3'd1;
    end else begin
      tx_cnt <= tx_cnt + CNT_W'(1);
    end
  end

  // TX shifter: load only from idle, so writes during a frame are dropped
  always_ff @(posedge clk) begin
    if ((tx_state == TX_IDLE) && wr_edge) begin
      tx_shift <= bus.serial_dataWrite;
    end else if ((tx_state == TX_DATA) && tx_bit_end) begin
      tx_shift <= {1'b0, tx_shift[BYTE_W-1:1]};
    end
  end

  assign uart_txd = tx_line;

  // ---------------- receiver ----------------
  logic              rxd_meta_p0;
  logic              rxd_sync_p1;
  logic              rxd_prev_p2;
  logic              rx_fall;
  rx_state_t         rx_state;
  rx_state_t         rx_next;
  logic [CNT_W-1:0]  rx_cnt;
  logic [2:0]        rx_bit;
  logic [BYTE_W-1:0] rx_shift;
  logic              rx_sample;
  logic              rx_push;

  assign rx_fall = rxd_prev_p2 & ~rxd_sync_p1;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_meta_p0 <= UART_IDLE;
      rxd_sync_p1 <= UART_IDLE;
      rxd_prev_p2 <= UART_IDLE;
    end else begin
      rxd_meta_p0 <= uart_rxd;
      rxd_sync_p1 <= rxd_meta_p0;
      rxd_prev_p2 <= rxd_sync_p1;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rx_state <= RX_IDLE;
    else      rx_state <= rx_next;
  end

  // RX next state: start bit re-checked at mid-bit to reject glitches
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_sample) rx_next = rxd_sync_p1 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_sample && (rx_bit == LAST_BIT)) rx_next = RX_STOP;
      RX_STOP:  if (rx_sample) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  // RX outputs: sample strobe at bit centres, push on a good stop bit
  always_comb begin
    rx_sample = 1'b0;
    rx_push   = 1'b0;
    case (rx_state)
      RX_START: rx_sample = (rx_cnt == HALF_LAST);
      RX_DATA:  rx_sample = (rx_cnt == BIT_LAST);
      RX_STOP:  begin
        rx_sample = (rx_cnt == BIT_LAST);
        rx_push   = rx_sample && (rxd_sync_p1 == UART_IDLE);
      end
      default:  rx_sample = 1'b0;
    endcase
  end

  // RX baud counter restarts at every sample so later samples stay centred
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else if (rx_state == RX_IDLE) begin
      rx_cnt <= '0;
      rx_bit <= '0;
    end else if (rx_sample) begin
      rx_cnt <= '0;
      if (rx_state == RX_DATA) rx_bit <= rx_bit + 3'd1;
    end else begin
      rx_cnt <= rx_cnt + CNT_W'(1);
    end
  end

  // RX shifter, LSB arrives first
  always_ff @(posedge clk) begin
    if ((rx_state == RX_DATA) && rx_sample) begin
      rx_shift <= {rxd_sync_p1, rx_shift[BYTE_W-1:1]};
    end
  end

  // ---------------- receive FIFO and status ----------------
  logic [BYTE_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic [FCNT_W-1:0] fifo_count;
  logic              fetch_pop;
  logic              overrun_q;
  logic [1:0]        status;

  assign fetch_pop = fetch_edge & ~fifo_empty;

  uart_rx_fifo #(
    .DEPTH  (RX_DEPTH),
    .DATA_W (BYTE_W)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .pop   (fetch_pop),
    .din   (rx_shift),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Sticky overrun: a frame arrived with nowhere to go
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overrun_q <= 1'b0;
    end else if (rx_push && fifo_full && !fetch_pop) begin
      overrun_q <= 1'b1;
    end
  end

  assign status               = status_bits(tx_idle, fifo_count != '0);
  assign bus.send_complete    = status[STAT_SEND_COMPLETE];
  assign bus.receive_complete = status[STAT_RECEIVE_COMPLETE];
  assign bus.serial_dataRead  = fifo_dout;
  assign bus.rx_overrun       = overrun_q;

endmodule

// File: tb/tb_uart_serial_ctrl.sv
// Bench for uart_serial_ctrl: directed stimulus, queue-based scoreboard with
// independent monitors for transmitted frames and CPU reads.
module tb_uart_serial_ctrl;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_rxd = 1'b1;
  logic uart_txd;

  uart_serial_ctrl_if bus();

  uart_serial_ctrl #(
    .CLKS_PER_BIT (CPB),
    .RX_DEPTH     (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .uart_rxd (uart_rxd),
    .uart_txd (uart_txd)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b, input int hold);
    bus.serial_dataWrite = b;
    bus.serial_readWrite = 1'b1;
    tick(hold);
    bus.serial_readWrite = 1'b0;
  endtask

  task automatic fetch();
    bus.serial_fetch_data = 1'b1;
    tick(1);
    bus.serial_fetch_data = 1'b0;
  endtask

  // Drive one 8N1 frame; the expected read is queued as the frame is issued
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    if (stop_bit && exp_rx.size() < 4) exp_rx.push_back(b);
    uart_rxd = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      tick(CPB);
    end
    uart_rxd = stop_bit;
    tick(CPB);
    uart_rxd = 1'b1;
  endtask

  // TX monitor: decode frames on uart_txd at bit centres and score them
  initial begin : tx_mon
    int         cnt;
    int         k;
    logic       busy;
    logic [7:0] sh;
    busy = 1'b0;
    cnt  = 0;
    sh   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        busy = 1'b0;
      end else if (!busy) begin
        if (uart_txd == 1'b0) begin
          busy = 1'b1;
          cnt  = 0;
        end
      end else begin
        cnt++;
        if (cnt == CPB / 2) begin
          if (uart_txd !== 1'b0) busy = 1'b0;
        end else if (cnt > CPB / 2 && ((cnt - CPB / 2) % CPB) == 0) begin
          k = (cnt - CPB / 2) / CPB;
          if (k <= 8) begin
            sh[k-1] = uart_txd;
          end else begin
            busy = 1'b0;
            if (exp_tx.size() == 0) begin
              n_cmp++;
              n_fail++;
              $display("FAIL tx_unexpected: got frame %0h, expected none", sh);
            end else begin
              check("tx_frame", sh, exp_tx.pop_front());
              check("tx_stop_bit", uart_txd, 1);
            end
          end
        end
      end
    end
  end

  // Read monitor: on each fetch edge compare the presented head byte
  initial begin : rd_mon
    logic prev;
    logic lvl;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      lvl = bus.serial_enable & bus.serial_fetch_data;
      if (!rst) begin
        prev = 1'b0;
      end else begin
        if (lvl && !prev) begin
          if (exp_rx.size() != 0) begin
            check("rx_read", bus.serial_dataRead, exp_rx.pop_front());
            check("rx_avail_at_read", bus.receive_complete, 1);
          end else begin
            check("rx_read_empty", bus.serial_dataRead, 0);
            check("rx_flag_empty", bus.receive_complete, 0);
          end
        end
        prev = lvl;
      end
    end
  end

  initial begin : stim
    logic [9:0] frame;
    logic [7:0] seen;
    int         sc_low;

    bus.serial_enable     = 1'b1;
    bus.serial_readWrite  = 1'b0;
    bus.serial_fetch_data = 1'b0;
    bus.serial_dataWrite  = '0;
    rst = 1'b0;
    tick(3);
    check("rst_txd", uart_txd, 1);
    check("rst_send_complete", bus.send_complete, 1);
    check("rst_receive_complete", bus.receive_complete, 0);
    check("rst_dataRead", bus.serial_dataRead, 0);
    check("rst_overrun", bus.rx_overrun, 0);
    rst = 1'b1;
    tick(2);

    // Single frame 0x41, bit-exact line check
    exp_tx.push_back(8'h41);
    write_byte(8'h41, 1);
    frame  = {1'b1, 8'h41, 1'b0};
    sc_low = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        seen[c] = uart_txd;
        if (bus.send_complete == 1'b0) sc_low++;
        tick(1);
      end
      check($sformatf("tx41_bit%0d", b), seen, {8{frame[b]}});
    end
    check("tx41_busy_cycles", sc_low, 80);
    check("tx41_done", bus.send_complete, 1);

    // Held strobe sends once; write during the frame is dropped
    tick(2);
    exp_tx.push_back(8'h55);
    write_byte(8'h55, 20);
    tick(10);
    write_byte(8'h33, 1);
    check("tx_busy_during_drop", bus.send_complete, 0);
    tick(90);
    check("tx_idle_after_55", bus.send_complete, 1);

    // Disabled block ignores the write strobe
    bus.serial_enable = 1'b0;
    write_byte(8'h99, 1);
    tick(2);
    check("tx_disabled_ignored", bus.send_complete, 1);
    bus.serial_enable = 1'b1;
    tick(2);

    // Receive 0xA5 and drain it
    send_rx(8'hA5, 1'b1);
    tick(1);
    check("rxA5_available", bus.receive_complete, 1);
    check("rxA5_head", bus.serial_dataRead, 8'hA5);
    fetch();
    check("rxA5_drained_flag", bus.receive_complete, 0);
    check("rxA5_drained_data", bus.serial_dataRead, 0);

    // Short glitch and framing error push nothing
    tick(5);
    uart_rxd = 1'b0;
    tick(3);
    uart_rxd = 1'b1;
    tick(20);
    check("glitch_no_push", bus.receive_complete, 0);
    send_rx(8'h5A, 1'b0);
    tick(20);
    check("frame_err_no_push", bus.receive_complete, 0);
    check("frame_err_no_overrun", bus.rx_overrun, 0);

    // Five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send_rx(8'(i), 1'b1);
    tick(2);
    check("overrun_set", bus.rx_overrun, 1);
    check("overrun_data_avail", bus.receive_complete, 1);
    for (int i = 0; i < 5; i++) begin
      fetch();
      tick(1);
    end
    check("overrun_drained", bus.receive_complete, 0);
    check("overrun_sticky", bus.rx_overrun, 1);

    // Reset during bit 3 of a 0xC3 frame
    write_byte(8'hC3, 1);
    tick(35);
    check("pre_rst_txd_bit3", uart_txd, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_txd", uart_txd, 1);
    check("rst_mid_send_complete", bus.send_complete, 1);
    tick(3);
    check("rst_mid_overrun_clr", bus.rx_overrun, 0);
    check("rst_mid_fifo_empty", bus.receive_complete, 0);
    check("rst_mid_dataRead", bus.serial_dataRead, 0);
    rst = 1'b1;
    tick(2);
    check("post_rst_send_complete", bus.send_complete, 1);
    exp_tx.push_back(8'h7E);
    write_byte(8'h7E, 1);
    tick(100);

    for (int i = 0; i < 2000 && exp_tx.size() != 0; i++) tick(1);
    check("tx_queue_drained", exp_tx.size(), 0);
    check("rx_queue_drained", exp_rx.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
